// File: rtl/cfg_flip_flop_pkg.sv
// Shared definitions for the configurable D/T flip-flop cell:
// the FF_TYPE encoding, the internal mode enum and parameter helpers.
package cfg_flip_flop_pkg;

  // Encoding of the FF_TYPE parameter seen by users of cfg_flip_flop.
  localparam int FF_TYPE_D = 0;
  localparam int FF_TYPE_T = 1;

  // Internal, strongly typed view of the storage behaviour.
  typedef enum logic {
    FF_MODE_D = 1'b0,  // capture d
    FF_MODE_T = 1'b1   // toggle bits where d = 1
  } ff_mode_e;

  // True only for the two supported FF_TYPE encodings.
  function automatic bit ff_type_valid(input int ff_type);
    return (ff_type == FF_TYPE_D) || (ff_type == FF_TYPE_T);
  endfunction

  // Maps a validated FF_TYPE onto the internal mode enum.
  function automatic ff_mode_e ff_mode_of(input int ff_type);
    return (ff_type == FF_TYPE_T) ? FF_MODE_T : FF_MODE_D;
  endfunction

endpackage : cfg_flip_flop_pkg

// File: rtl/cfg_ff_bit.sv
// One-bit storage cell: asynchronous active-high reset register,
// D/T next-state selection and the complementary output inverter.
module cfg_ff_bit
  import cfg_flip_flop_pkg::*;
#(
  parameter ff_mode_e MODE      = FF_MODE_D,
  parameter logic     RESET_BIT = 1'b0
) (
  input  logic clk,
  input  logic rstn,   // active-high despite the name
  input  logic d,
  output logic q,
  output logic qbar
);

  logic q_q;
  logic q_d;

  // Next-state selection: capture d, or toggle the stored bit when d is set.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves q_d unassigned (no latch).
    q_d = q_q;
    if (MODE == FF_MODE_T) begin
      q_d = q_q ^ d;
    end else begin
      q_d = d;
    end
  end

  // State register; reset is asynchronous and takes priority over the clock edge.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      // NOTE: sequential state uses <= so every flop samples pre-edge values.
      q_q <= RESET_BIT;
    end else begin
      q_q <= q_d;
    end
  end

  assign q    = q_q;
  assign qbar = ~q_q;

endmodule : cfg_ff_bit

// File: rtl/cfg_flip_flop.sv
// Configurable register: WIDTH independent D or T flip-flop bits sharing one
// clock and one asynchronous active-high reset, with true and complement outputs.
module cfg_flip_flop
  import cfg_flip_flop_pkg::*;
#(
  parameter int               FF_TYPE     = FF_TYPE_T,
  parameter int               WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = {WIDTH{1'b0}}
) (
  input  logic             clk,
  input  logic             rstn,   // 1 = reset asserted
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qbar
);

  // Elaboration-time parameter checks: an unsupported configuration must stop
  // the build rather than quietly falling back to some default behaviour.
  if (!ff_type_valid(FF_TYPE)) begin : g_bad_ff_type
    $fatal(1, "cfg_flip_flop: FF_TYPE=%0d is illegal, use 0 (D) or 1 (T)", FF_TYPE);
  end

  if (WIDTH < 1) begin : g_bad_width
    $fatal(1, "cfg_flip_flop: WIDTH=%0d is illegal, must be >= 1", WIDTH);
  end

  localparam ff_mode_e MODE = ff_mode_of(FF_TYPE);

  // One leaf cell per bit; each receives its own slice of RESET_VALUE.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    cfg_ff_bit #(
      .MODE      (MODE),
      .RESET_BIT (RESET_VALUE[i])
    ) u_bit (
      .clk  (clk),
      .rstn (rstn),
      .d    (d[i]),
      .q    (q[i]),
      .qbar (qbar[i])
    );
  end

endmodule : cfg_flip_flop

// File: tb/tb_cfg_flip_flop.sv
// Self-checking bench for cfg_flip_flop: an 8-bit D register, an 8-bit
// T register and a 4-bit T register with a non-zero reset value, all sharing
// clk and rstn. A behavioural model is compared every falling edge, and
// directed literal checks pin the model and the reset corner cases.
module tb_cfg_flip_flop;

  logic       clk;
  logic       rstn;
  logic [7:0] d_d, d_t;
  logic [3:0] d_v;
  logic [7:0] q_d, qbar_d, q_t, qbar_t;
  logic [3:0] q_v, qbar_v;

  int checks = 0;
  int errors = 0;
  bit check_en = 1'b0;

  // Behavioural model state, one per instance.
  logic [7:0] m_d, m_t;
  logic [3:0] m_v;

  localparam logic [3:0] V_RESET = 4'b1010;

  cfg_flip_flop #(.FF_TYPE(0), .WIDTH(8), .RESET_VALUE(8'h00)) dut_d (
    .clk(clk), .rstn(rstn), .d(d_d), .q(q_d), .qbar(qbar_d)
  );

  cfg_flip_flop #(.FF_TYPE(1), .WIDTH(8), .RESET_VALUE(8'h00)) dut_t (
    .clk(clk), .rstn(rstn), .d(d_t), .q(q_t), .qbar(qbar_t)
  );

  cfg_flip_flop #(.FF_TYPE(1), .WIDTH(4), .RESET_VALUE(V_RESET)) dut_v (
    .clk(clk), .rstn(rstn), .d(d_v), .q(q_v), .qbar(qbar_v)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: an edge seen with reset asserted loads the reset value; otherwise
  // a D register takes d and a T register flips the bits selected by d.
  always @(posedge clk) begin
    if (rstn) begin
      m_d = 8'h00;
      m_t = 8'h00;
      m_v = V_RESET;
    end else begin
      m_d = d_d;
      m_t = m_t ^ d_t;
      m_v = m_v ^ d_v;
    end
  end

  // Compare every falling edge once the model has been through a reset.
  always @(negedge clk) begin
    if (check_en) begin
      check("model_q_d",    {24'b0, q_d},    {24'b0, m_d});
      check("model_qbar_d", {24'b0, qbar_d}, {24'b0, ~m_d});
      check("model_q_t",    {24'b0, q_t},    {24'b0, m_t});
      check("model_qbar_t", {24'b0, qbar_t}, {24'b0, ~m_t});
      check("model_q_v",    {28'b0, q_v},    {28'b0, m_v});
      check("model_qbar_v", {28'b0, qbar_v}, {28'b0, ~m_v});
    end
  end

  // Guard against a hung run.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] seq_d   [4];
    logic [7:0] seq_exp [4];
    seq_d   = '{8'h01, 8'h01, 8'h00, 8'h01};
    seq_exp = '{8'h01, 8'h00, 8'h00, 8'h01};

    rstn = 1'b1;
    d_d  = '0;
    d_t  = '0;
    d_v  = '0;
    @(posedge clk);
    #1 check_en = 1'b1;

    // Reset hold with random d: outputs must stay at the reset value.
    repeat (50) begin
      @(negedge clk);
      d_d = 8'($urandom);
      d_t = 8'($urandom);
      d_v = 4'($urandom);
    end
    @(negedge clk);
    check("rst_q_d",    {24'b0, q_d},    32'h00);
    check("rst_qbar_t", {24'b0, qbar_t}, 32'hff);
    check("rst_q_v",    {28'b0, q_v},    32'h0a);
    check("rst_qbar_v", {28'b0, qbar_v}, 32'h05);
    d_d = '0;
    d_t = '0;
    d_v = '0;
    rstn = 1'b0;  // deasserted away from any clock edge

    // Random operation of D and T registers.
    repeat (1000) begin
      @(negedge clk);
      d_d = 8'($urandom);
      d_t = 8'($urandom);
      d_v = 4'($urandom);
    end

    // Pin D mode: one clock latency.
    @(negedge clk);
    d_d = 8'ha5;
    @(negedge clk);
    check("d_lit_q",    {24'b0, q_d},    32'ha5);
    check("d_lit_qbar", {24'b0, qbar_d}, 32'h5a);

    // Pin T mode from zero: d 1,1,0,1 gives q 1,0,0,1.
    rstn = 1'b1;
    d_t  = '0;
    @(negedge clk);
    rstn = 1'b0;
    d_t  = seq_d[0];
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check($sformatf("t_seq_%0d", i), {24'b0, q_t}, {24'b0, seq_exp[i]});
      d_t = (i < 3) ? seq_d[i+1] : 8'h00;
    end

    // Asynchronous reset mid-cycle while q_t = 1.
    #2 rstn = 1'b1;
    #1;
    check("async_q_t",    {24'b0, q_t},    32'h00);
    check("async_qbar_t", {24'b0, qbar_t}, 32'hff);
    check("async_q_v",    {28'b0, q_v},    32'h0a);

    // Reset deassert coincident with a rising edge: that edge still resets.
    d_t = 8'h01;
    d_v = 4'b0110;
    @(negedge clk);
    @(posedge clk);
    rstn <= 1'b0;
    @(negedge clk);
    check("coinc_q_t", {24'b0, q_t}, 32'h00);
    check("coinc_q_v", {28'b0, q_v}, 32'h0a);
    d_t = 8'h01;
    @(negedge clk);
    check("after_q_t",    {24'b0, q_t},    32'h01);
    check("vec_q_v",      {28'b0, q_v},    32'h0c);
    check("vec_qbar_v",   {28'b0, qbar_v}, 32'h03);
    d_t = '0;
    d_v = '0;

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_cfg_flip_flop

// File: doc/cfg_flip_flop.md
Name: cfg_flip_flop

Overview:
- Single-clock storage element whose behaviour is chosen at elaboration by FF_TYPE: D flip-flop (0) or T flip-flop (1).
- Provides true and complementary outputs.
- Used as a leaf cell in datapath and control logic wherever a configurable register bit or vector is needed.
- WIDTH allows the same cell to be used as a vector register. All bits share the clock and reset.

Parameters:
- FF_TYPE, 1, storage type: 0 = D (capture d), 1 = T (toggle where d=1). Any other value is an elaboration error.
- WIDTH, 1, bit width of d, q and qbar; must be >= 1.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into q while reset is asserted.

Ports:
- clk  input  1  clock; all state changes occur on the rising edge, except reset.
- rstn  input  1  asynchronous, active-high reset. 1 = reset asserted, despite the "n" in the name.
- d  input  WIDTH  data input in D mode; per-bit toggle enable in T mode.
- q  output  WIDTH  registered state.
- qbar  output  WIDTH  bitwise complement of q.

Behaviour:
- Reset:
  - While rstn=1, q = RESET_VALUE immediately, with no clock needed, and qbar = ~RESET_VALUE.
  - Clock edges are ignored while reset is held.
- Reset deassertion:
  - rstn falling to 0 does not change q.
  - The first active update is the first rising clk edge where rstn=0 at the edge.
- D mode (FF_TYPE=0): at each rising clk edge with rstn=0, q <= d. Latency is 1 clock.
- T mode (FF_TYPE=1): at each rising clk edge with rstn=0, q <= q ^ d (per bit).
  - d=0 holds the bit.
  - d=1 inverts the bit.
  - Sustained d=1 gives a divide-by-2 square wave on q.
- qbar:
  - Combinational ~q at all times, including during reset.
  - qbar is never equal to q in any bit.
- Reset mid-operation: asserting rstn at any time, including coincident with a rising clk edge, forces RESET_VALUE. Reset wins over the clock.
- Simultaneous rstn deassert and clk edge: the edge is treated as reset still active, so q stays RESET_VALUE.
- No X propagation from reset. q has no unknown state after the first reset.
- Before the first reset, q is undefined. The bench must apply reset first.
- Parameter checks:
  - An illegal FF_TYPE or WIDTH < 1 triggers an elaboration-time fatal.
  - There is no silent fallback.

Decomposition:
- Shared package holds:
  - FF_TYPE encoding constants: FF_TYPE_D = 0, FF_TYPE_T = 1.
  - A helper function that validates FF_TYPE.
- One sub-module, cfg_ff_bit: a 1-bit cell containing the async-reset register, the D/T next-state mux and the qbar inverter.
- The top level generates WIDTH instances of cfg_ff_bit and fans out RESET_VALUE bits to them.
- The top level also holds the parameter assertions.

Test Plan:
1. Reset hold (both types): rstn=1 for 50 clocks with random d. Check q=0 and qbar=all-ones at every falling edge.
2. Async reset: with rstn=0, T mode and q=1, raise rstn mid-cycle, away from any clk edge. q must go to 0 before the next rising edge.
3. D mode random: rstn=0, apply 1000 random d values, each set before a rising edge. At the following falling edge, q equals that d and qbar = ~d.
4. T mode random: rstn=0, model starts at 0, apply 1000 random d values.
   - Each edge with d=1 inverts the model; d=0 holds it.
   - Check q equals the model at every falling edge.
   - Example: d sequence 1,1,0,1 gives q = 1,0,0,1.
5. Deassert/edge coincidence: drop rstn on the same rising edge with d=1 (T mode). q stays 0 at that edge and becomes 1 on the next edge.
6. Vector/RESET_VALUE: WIDTH=4, RESET_VALUE=4'b1010, T mode.
   - Reset gives q=1010.
   - d=4'b0110 on one edge gives q=1100 and qbar=0011.
